// File: rtl/rd3_sched_if.sv
// rd3_sched_if: sample-in, sample-out and butterfly buses of the radix-3 scheduler
interface rd3_sched_if #(
  parameter int D_SIZE = 13
);
  logic              s_vld;
  logic              s_rdy;
  logic [D_SIZE-1:0] s_re;
  logic [D_SIZE-1:0] s_im;
  logic              m_vld;
  logic              m_rdy;
  logic [D_SIZE+1:0] m_re;
  logic [D_SIZE+1:0] m_im;
  logic [1:0]        m_idx;
  logic              bf_di_vld;
  logic [D_SIZE-1:0] bf_in1_re, bf_in1_im, bf_in2_re, bf_in2_im, bf_in3_re, bf_in3_im;
  logic              bf_do_vld;
  logic [D_SIZE+1:0] bf_out1_re, bf_out1_im, bf_out2_re, bf_out2_im, bf_out3_re, bf_out3_im;
  modport master (
    input  s_vld, s_re, s_im, m_rdy, bf_do_vld,
    input  bf_out1_re, bf_out1_im, bf_out2_re, bf_out2_im, bf_out3_re, bf_out3_im,
    output s_rdy, m_vld, m_re, m_im, m_idx, bf_di_vld,
    output bf_in1_re, bf_in1_im, bf_in2_re, bf_in2_im, bf_in3_re, bf_in3_im
  );
  modport slave (
    output s_vld, s_re, s_im, m_rdy, bf_do_vld,
    output bf_out1_re, bf_out1_im, bf_out2_re, bf_out2_im, bf_out3_re, bf_out3_im,
    input  s_rdy, m_vld, m_re, m_im, m_idx, bf_di_vld,
    input  bf_in1_re, bf_in1_im, bf_in2_re, bf_in2_im, bf_in3_re, bf_in3_im
  );
endinterface

// File: rtl/rd3_sched.sv
// rd3_sched: packs three serial samples into one radix-3 butterfly issue and serializes its results; RD3_SCHED_SAT_EN clips captured results to the D_SIZE range
module rd3_sched #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 6,
  parameter int FLT_BIT  = 6,
  parameter int D_SIZE   = SIGN_BIT + INT_BIT + FLT_BIT,
  parameter int TO_CYC   = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  rd3_sched_if.master        bus,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_spur,
  output logic [15:0]        grp_cnt,
  output logic               m_sat
);
  localparam int OW = D_SIZE + 2;
  localparam int TW = $clog2(TO_CYC + 1);
  typedef enum logic [1:0] {LOAD, FIRE, WAIT, SEND} state_t;
  state_t            state;
  logic [1:0]        slot;
  logic [TW-1:0]     timer;
  logic [D_SIZE-1:0] op_re [3];
  logic [D_SIZE-1:0] op_im [3];
  logic [OW-1:0]     res_re [3];
  logic [OW-1:0]     res_im [3];
  logic [OW-1:0]     cap_re [3];
  logic [OW-1:0]     cap_im [3];
  logic              bf_di_vld;
  logic              m_vld;
  logic [1:0]        m_idx;
`ifdef RD3_SCHED_SAT_EN
  function automatic logic [OW-1:0] fit(input logic [OW-1:0] x);
    return (&x[OW-1:D_SIZE-1] || ~|x[OW-1:D_SIZE-1]) ? x : {{3{x[OW-1]}}, {(D_SIZE-1){~x[OW-1]}}};
  endfunction
  // Sticky: set when any captured result had to be clipped
  always_ff @(posedge clk)
    if (n_rst) m_sat <= 1'b0;
    else if (state == WAIT && bus.bf_do_vld &&
             (cap_re[0] != bus.bf_out1_re || cap_im[0] != bus.bf_out1_im ||
              cap_re[1] != bus.bf_out2_re || cap_im[1] != bus.bf_out2_im ||
              cap_re[2] != bus.bf_out3_re || cap_im[2] != bus.bf_out3_im)) m_sat <= 1'b1;
`else
  function automatic logic [OW-1:0] fit(input logic [OW-1:0] x);
    return x;
  endfunction
  assign m_sat = 1'b0;
`endif
  // Butterfly results in the form they are stored for serialization
  always_comb begin
    cap_re[0] = fit(bus.bf_out1_re);
    cap_im[0] = fit(bus.bf_out1_im);
    cap_re[1] = fit(bus.bf_out2_re);
    cap_im[1] = fit(bus.bf_out2_im);
    cap_re[2] = fit(bus.bf_out3_re);
    cap_im[2] = fit(bus.bf_out3_im);
  end
  // Load three samples, issue, wait for result or timeout, then serialize three outputs
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state       <= LOAD;
      slot        <= '0;
      timer       <= '0;
      bf_di_vld   <= 1'b0;
      m_vld       <= 1'b0;
      m_idx       <= '0;
      err_timeout <= 1'b0;
      err_spur    <= 1'b0;
      grp_cnt     <= '0;
      for (int i = 0; i < 3; i++) begin
        op_re[i]  <= '0;
        op_im[i]  <= '0;
        res_re[i] <= '0;
        res_im[i] <= '0;
      end
    end else begin
      if (bus.bf_do_vld && state != WAIT) err_spur <= 1'b1;
      case (state)
        LOAD: if (bus.s_vld) begin
          op_re[slot] <= bus.s_re;
          op_im[slot] <= bus.s_im;
          slot        <= slot == 2'd2 ? 2'd0 : slot + 2'd1;
          if (slot == 2'd2) begin
            state     <= FIRE;
            bf_di_vld <= 1'b1;
          end
        end
        FIRE: begin
          bf_di_vld <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: if (bus.bf_do_vld) begin
          for (int i = 0; i < 3; i++) begin
            res_re[i] <= cap_re[i];
            res_im[i] <= cap_im[i];
          end
          m_idx <= '0;
          m_vld <= 1'b1;
          state <= SEND;
        end else if (timer == TW'(TO_CYC - 1)) begin
          err_timeout <= 1'b1;
          state       <= LOAD;
        end else timer <= timer + 1'b1;
        SEND: if (bus.m_rdy) begin
          m_idx <= m_idx == 2'd2 ? 2'd0 : m_idx + 2'd1;
          if (m_idx == 2'd2) begin
            m_vld   <= 1'b0;
            grp_cnt <= grp_cnt + 16'd1;
            state   <= LOAD;
          end
        end
      endcase
    end
  end
  assign bus.s_rdy     = state == LOAD && !n_rst;
  assign busy          = state != LOAD || slot != 2'd0;
  assign bus.bf_di_vld = bf_di_vld;
  assign bus.bf_in1_re = op_re[0];
  assign bus.bf_in1_im = op_im[0];
  assign bus.bf_in2_re = op_re[1];
  assign bus.bf_in2_im = op_im[1];
  assign bus.bf_in3_re = op_re[2];
  assign bus.bf_in3_im = op_im[2];
  assign bus.m_vld     = m_vld;
  assign bus.m_idx     = m_idx;
  assign bus.m_re      = res_re[m_idx];
  assign bus.m_im      = res_im[m_idx];
endmodule

// File: tb/tb_rd3_sched.sv
// tb_rd3_sched: directed and randomized groups against a sample-level reference model
module tb_rd3_sched;
  localparam int D = 13;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic busy, err_timeout, err_spur, m_sat;
  logic [15:0] grp_cnt;
  int checks = 0;
  int fails = 0;
  int exp_grp = 0;
  logic exp_to = 1'b0, exp_sp = 1'b0, exp_sat = 1'b0;
  int q_re[$], q_im[$];
  int sa_re[3], sa_im[3];
  rd3_sched_if #(.D_SIZE(D)) bus ();
  rd3_sched dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .busy(busy), .err_timeout(err_timeout),
    .err_spur(err_spur), .grp_cnt(grp_cnt), .m_sat(m_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  function automatic int bfo(int k, int a, int b, int c);
    return k == 0 ? a + b + c : k == 1 ? a - b - c : b - c;
  endfunction
  function automatic int sat(int v);
`ifdef RD3_SCHED_SAT_EN
    return v > 4095 ? 4095 : v < -4096 ? -4096 : v;
`else
    return v;
`endif
  endfunction
  task automatic push(input int re, input int im);
    int n = 0;
    bus.s_vld = 1'b1;
    bus.s_re = 13'(re);
    bus.s_im = 13'(im);
    while (bus.s_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("s_rdy_wait", bus.s_rdy, 1);
    @(negedge clk);
  endtask
  task automatic issue(input int first);
    for (int i = first; i < 3; i++) push(sa_re[i], sa_im[i]);
    bus.s_vld = 1'b0;
    chk("bf_di_vld_hi", bus.bf_di_vld, 1);
    chk("in1_re", $signed(bus.bf_in1_re), sa_re[0]);
    chk("in1_im", $signed(bus.bf_in1_im), sa_im[0]);
    chk("in2_re", $signed(bus.bf_in2_re), sa_re[1]);
    chk("in2_im", $signed(bus.bf_in2_im), sa_im[1]);
    chk("in3_re", $signed(bus.bf_in3_re), sa_re[2]);
    chk("in3_im", $signed(bus.bf_in3_im), sa_im[2]);
    @(negedge clk);
    chk("bf_di_vld_lo", bus.bf_di_vld, 0);
    chk("s_rdy_wait_state", bus.s_rdy, 0);
  endtask
  task automatic respond(input int lat);
    repeat (lat) @(negedge clk);
    bus.bf_do_vld = 1'b1;
    bus.bf_out1_re = 15'(bfo(0, sa_re[0], sa_re[1], sa_re[2]));
    bus.bf_out2_re = 15'(bfo(1, sa_re[0], sa_re[1], sa_re[2]));
    bus.bf_out3_re = 15'(bfo(2, sa_re[0], sa_re[1], sa_re[2]));
    bus.bf_out1_im = 15'(bfo(0, sa_im[0], sa_im[1], sa_im[2]));
    bus.bf_out2_im = 15'(bfo(1, sa_im[0], sa_im[1], sa_im[2]));
    bus.bf_out3_im = 15'(bfo(2, sa_im[0], sa_im[1], sa_im[2]));
    @(negedge clk);
    bus.bf_do_vld = 1'b0;
    chk("m_vld_first", bus.m_vld, 1);
    chk("m_idx_first", bus.m_idx, 0);
    for (int k = 0; k < 3; k++) begin
      int r = bfo(k, sa_re[0], sa_re[1], sa_re[2]);
      int m = bfo(k, sa_im[0], sa_im[1], sa_im[2]);
      q_re.push_back(sat(r));
      q_im.push_back(sat(m));
      if (sat(r) != r || sat(m) != m) exp_sat = 1'b1;
    end
  endtask
  task automatic drain(input bit stall);
    int n = 0;
    int held = 0;
    while (q_re.size() > 0 && n < 200) begin
      n++;
      chk("m_vld", bus.m_vld, 1);
      chk("m_idx", bus.m_idx, 3 - q_re.size());
      chk("m_re", $signed(bus.m_re), q_re[0]);
      chk("m_im", $signed(bus.m_im), q_im[0]);
      chk("s_rdy_send", bus.s_rdy, 0);
      if (stall && q_re.size() == 2 && held < 5) begin
        bus.m_rdy = 1'b0;
        held++;
      end else bus.m_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus.m_rdy) begin
        void'(q_re.pop_front());
        void'(q_im.pop_front());
      end
    end
    if (q_re.size() != 0) begin
      chk("drain_bound", q_re.size(), 0);
      q_re.delete();
      q_im.delete();
    end
    bus.m_rdy = 1'b0;
    exp_grp++;
  endtask
  task automatic status();
    chk("m_vld_idle", bus.m_vld, 0);
    chk("grp_cnt", grp_cnt, exp_grp);
    chk("err_timeout", err_timeout, exp_to);
    chk("err_spur", err_spur, exp_sp);
    chk("m_sat", m_sat, exp_sat);
    chk("busy_idle", busy, 0);
    chk("s_rdy_idle", bus.s_rdy, 1);
  endtask
  task automatic rnd_group();
    for (int i = 0; i < 3; i++) begin
      sa_re[i] = int'($urandom_range(0, 8191)) - 4096;
      sa_im[i] = int'($urandom_range(0, 8191)) - 4096;
    end
  endtask
  initial begin
    bus.s_vld = 1'b0;
    bus.s_re = '0;
    bus.s_im = '0;
    bus.m_rdy = 1'b0;
    bus.bf_do_vld = 1'b0;
    bus.bf_out1_re = '0;
    bus.bf_out1_im = '0;
    bus.bf_out2_re = '0;
    bus.bf_out2_im = '0;
    bus.bf_out3_re = '0;
    bus.bf_out3_im = '0;
    repeat (2) @(negedge clk);
    chk("rst_s_rdy", bus.s_rdy, 0);
    chk("rst_m_vld", bus.m_vld, 0);
    chk("rst_bf_di_vld", bus.bf_di_vld, 0);
    chk("rst_m_idx", bus.m_idx, 0);
    chk("rst_bf_in1_re", bus.bf_in1_re, 0);
    chk("rst_m_re", bus.m_re, 0);
    chk("rst_grp_cnt", grp_cnt, 0);
    chk("rst_err", {err_timeout, err_spur, m_sat}, 0);
    n_rst = 1'b0;
    @(negedge clk);
    status();
    sa_re = '{64, 128, -64};
    sa_im = '{64, 128, -64};
    issue(0);
    respond(2);
    chk("basic_out1", q_re[0], 128);
    drain(1'b1);
    status();
    rnd_group();
    issue(0);
    repeat (15) @(negedge clk);
    chk("to_early", err_timeout, 0);
    chk("to_early_s_rdy", bus.s_rdy, 0);
    @(negedge clk);
    exp_to = 1'b1;
    status();
    rnd_group();
    push(sa_re[0], sa_im[0]);
    bus.s_vld = 1'b0;
    bus.bf_do_vld = 1'b1;
    @(negedge clk);
    bus.bf_do_vld = 1'b0;
    exp_sp = 1'b1;
    chk("spur_flag", err_spur, 1);
    chk("spur_m_vld", bus.m_vld, 0);
    chk("spur_busy", busy, 1);
    issue(1);
    respond(4);
    drain(1'b0);
    status();
    sa_re = '{2048, 2048, 2048};
    sa_im = '{-5, 7, 9};
    issue(0);
    respond(1);
`ifdef RD3_SCHED_SAT_EN
    chk("sat_out1", q_re[0], 4095);
`else
    chk("sat_out1", q_re[0], 6144);
`endif
    drain(1'b0);
    status();
    for (int g = 0; g < 20; g++) begin
      rnd_group();
      issue(0);
      respond(int'($urandom_range(0, 10)));
      drain(1'b0);
      status();
    end
    rnd_group();
    issue(0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_rdy", bus.s_rdy, 0);
    chk("mid_rst_m_vld", bus.m_vld, 0);
    chk("mid_rst_bf_in1", bus.bf_in1_re, 0);
    chk("mid_rst_grp", grp_cnt, 0);
    chk("mid_rst_err", {err_timeout, err_spur, m_sat}, 0);
    n_rst = 1'b0;
    exp_grp = 0;
    exp_to = 1'b0;
    exp_sp = 1'b0;
    exp_sat = 1'b0;
    @(negedge clk);
    status();
    bus.bf_do_vld = 1'b1;
    @(negedge clk);
    bus.bf_do_vld = 1'b0;
    exp_sp = 1'b1;
    status();
    rnd_group();
    issue(0);
    respond(3);
    drain(1'b0);
    status();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
